reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter ROB_ID_WIDTH, default 4, width of a reorder-buffer entry id; id 0 means "no producer / ready".
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 rdy  input  1  global ready; when low, no state update.
REQ-005 reset_from_rob_bus  input  1  misprediction flush from reorder buffer.
REQ-006 valid_from_issuer  input  1  rename request this cycle.
REQ-007 rd_from_issuer  input  5  destination register being renamed.
REQ-008 dest_from_issuer  input  ROB_ID_WIDTH  ROB id assigned to rd_from_issuer.
REQ-009 rs1_from_issuer, rs2_from_issuer  input  5 each  source operand indices.
REQ-010 qj_to_issuer, qk_to_issuer  output  ROB_ID_WIDTH each  producer tag for rs1/rs2, 0 = value valid.
REQ-011 vj_to_issuer, vk_to_issuer  output  32 each  operand values for rs1/rs2, 0 when tag nonzero.
REQ-012 dest_from_rob  input  ROB_ID_WIDTH  committing entry id, 0 = no commit.
REQ-013 rd_from_rob  input  5  committed destination register.
REQ-014 value_from_rob  input  32  committed value.

Function
REQ-015 Storage: 32 x 32-bit value array plus 32 x ROB_ID_WIDTH tag array.
REQ-016 Register x0: value and tag permanently 0; rename and commit targeting x0 ignored.
REQ-017 Commit (dest_from_rob != 0, rd_from_rob != 0): value[rd] <= value_from_rob next edge.
REQ-018 Commit clears tag[rd] to 0 only if tag[rd] == dest_from_rob; otherwise tag unchanged (younger producer pending).
REQ-019 Rename (valid_from_issuer, rd_from_issuer != 0): tag[rd] <= dest_from_issuer next edge.
REQ-020 Rename and commit same register same cycle: rename tag wins; commit value still written.
REQ-021 Operand read combinational, zero latency, for each of rs1/rs2 independently.
REQ-022 tag[rs] == 0: q = 0, v = value[rs].
REQ-023 tag[rs] != 0 and same-cycle commit with dest_from_rob == tag[rs] and rd_from_rob == rs: bypass, q = 0, v = value_from_rob.
REQ-024 Otherwise: q = tag[rs], v = 0.
REQ-025 Operand reads reflect state before this cycle's rename (instruction never depends on its own rd).
REQ-026 Flush (reset_from_rob_bus high, rdy high): all tags <= 0 next edge; values kept; same-cycle commit value write still applied; same-cycle rename ignored.
REQ-027 rdy low: tag and value arrays hold; read outputs remain combinationally valid.
REQ-028 rs1 == rs2 allowed; both ports return identical q/v.

Reset
REQ-029 rst high: immediately (without clock) all values and tags 0; outputs therefore q = 0, v = 0 for every index.
REQ-030 rst has priority over flush, rename, commit, rdy.
REQ-031 After rst deasserts, first rising edge already accepts rename/commit.

Verification
REQ-032 Rename x5->tag 3; next cycle read rs1=5 -> qj=3, vj=0; commit dest=3 rd=5 value=0x1234 -> same cycle qj=0, vj=0x1234 (bypass); following cycle tag 0, vj=0x1234.
REQ-033 Rename x7->2, then x7->4; commit dest=2 rd=7 value=0xAA -> value[7]=0xAA, read rs2=7 still qk=4, vk=0.
REQ-034 Same cycle rename x9->6 and commit dest=1 rd=9 (tag[9]=1) value=0x55 -> next cycle tag[9]=6, value[9]=0x55.
REQ-035 Rename x1->1, x2->2, x3->3; flush with commit dest=5 rd=4 value=0x77 -> next cycle all q=0, x1..x3 old values, x4=0x77.
REQ-036 Rename and commit to x0 value=0xFFFF -> reads of x0 return q=0, v=0 forever.
REQ-037 Assert rst asynchronously between edges with tags pending -> outputs drop to q=0, v=0 before next edge; rdy low cycle with rename request -> no tag change.

Source files
------------

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Architectural register file with register-renaming tags for an
//   out-of-order core. Each of the 32 registers holds a 32-bit committed
//   value and a ROB id tag naming its newest in-flight producer (0 = value is
//   current). The issuer renames a destination and reads two source operands
//   combinationally. The reorder buffer commits results and can flush all
//   pending tags on a misprediction.
//
// Parameters
//   ROB_ID_WIDTH        width of a reorder-buffer id (id 0 = no producer)
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset, clears values and tags
//   rdy                 global ready; low freezes all state
//   reset_from_rob_bus  misprediction flush: clear every tag
//   valid_from_issuer   rename request this cycle
//   rd_from_issuer      register being renamed
//   dest_from_issuer    ROB id given to rd_from_issuer
//   rs1/rs2_from_issuer source operand indices
//   qj/qk_to_issuer     producer tags for rs1/rs2 (0 = value valid)
//   vj/vk_to_issuer     operand values for rs1/rs2 (0 while tag pending)
//   dest_from_rob       committing ROB id (0 = no commit)
//   rd_from_rob         committed destination register
//   value_from_rob      committed value
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    reset_from_rob_bus,
  input  logic                    valid_from_issuer,
  input  logic [4:0]              rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  input  logic [4:0]              rs1_from_issuer,
  input  logic [4:0]              rs2_from_issuer,
  output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
  output logic [31:0]             vj_to_issuer,
  output logic [31:0]             vk_to_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
  input  logic [4:0]              rd_from_rob,
  input  logic [31:0]             value_from_rob
);

  localparam int NUM_REGS = 32;
  localparam int OPND_W   = ROB_ID_WIDTH + 32;

  logic [31:0]             value_q [NUM_REGS];
  logic [ROB_ID_WIDTH-1:0] tag_q   [NUM_REGS];

  logic commit_en;
  logic rename_en;

  // x0 is hard-wired to zero, so commits and renames aimed at it are dropped.
  assign commit_en = (dest_from_rob != '0) && (rd_from_rob != 5'd0);
  assign rename_en = valid_from_issuer && (rd_from_issuer != 5'd0);

  // Resolve one source operand: {q, v}. A commit landing this very cycle on
  // the producer we would otherwise wait for is forwarded so the issuer does
  // not miss the broadcast. State is read before this cycle's rename, so an
  // instruction never waits on its own destination.
  function automatic logic [OPND_W-1:0] read_operand(
    input logic [4:0]              rs,
    input logic [ROB_ID_WIDTH-1:0] tag,
    input logic [31:0]             value,
    input logic                    commit,
    input logic [ROB_ID_WIDTH-1:0] commit_dest,
    input logic [4:0]              commit_rd,
    input logic [31:0]             commit_value
  );
    logic [ROB_ID_WIDTH-1:0] q;
    logic [31:0]             v;
    if (tag == '0) begin
      q = '0;
      v = value;
    end else if (commit && (commit_dest == tag) && (commit_rd == rs)) begin
      q = '0;
      v = commit_value;
    end else begin
      q = tag;
      v = '0;
    end
    return {q, v};
  endfunction

  always_comb begin
    {qj_to_issuer, vj_to_issuer} = read_operand(
      rs1_from_issuer, tag_q[rs1_from_issuer], value_q[rs1_from_issuer],
      commit_en, dest_from_rob, rd_from_rob, value_from_rob);
    {qk_to_issuer, vk_to_issuer} = read_operand(
      rs2_from_issuer, tag_q[rs2_from_issuer], value_q[rs2_from_issuer],
      commit_en, dest_from_rob, rd_from_rob, value_from_rob);
  end

  // State update: commit writes the value; tag is cleared only when the
  // committing entry is still the newest producer. A same-cycle rename is
  // written last so it overrides the clear. Flush wipes all tags and
  // suppresses the rename, but a concurrent commit value still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      if (commit_en) begin
        value_q[rd_from_rob] <= value_from_rob;
      end
      if (reset_from_rob_bus) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          tag_q[i] <= '0;
        end
      end else begin
        if (commit_en && (tag_q[rd_from_rob] == dest_from_rob)) begin
          tag_q[rd_from_rob] <= '0;
        end
        if (rename_en) begin
          tag_q[rd_from_issuer] <= dest_from_issuer;
        end
      end
    end
  end

endmodule
